// File: rtl/sliding_window_fp.sv
// Streaming zero-padded 2-D window generator with line buffers and a window shift register.
// Define SLIDING_WINDOW_REPLICATE_EN to replicate edge pixels instead of zero padding.
module sliding_window_fp #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int WINDOW_WIDTH  = 5,
    parameter int WINDOW_HEIGHT = 5,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
    localparam int HW           = WINDOW_WIDTH / 2,
    localparam int HH           = WINDOW_HEIGHT / 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] pixel_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int ADDR_W = $clog2(IMAGE_WIDTH);
    localparam logic [15:0] LAST_REAL_COL = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_REAL_ROW = 16'(IMAGE_HEIGHT - 1);
    localparam logic [15:0] LAST_VCOL     = 16'(IMAGE_WIDTH + HW - 1);
    localparam logic [15:0] LAST_VROW     = 16'(IMAGE_HEIGHT + HH - 1);

    typedef enum logic [1:0] {ACCEPT, ROW_PAD, FRAME_PAD} state_t;

    state_t                  state;
    logic [15:0]             vcol;
    logic [15:0]             vrow;
    logic [FP_WIDTH_REG-1:0] line_buf [WINDOW_HEIGHT-1][IMAGE_WIDTH];
    logic [FP_WIDTH_REG-1:0] win      [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] win_next [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] win_out  [WINDOW_HEIGHT][WINDOW_WIDTH];
    logic [FP_WIDTH_REG-1:0] col_in   [WINDOW_HEIGHT];
    logic [FP_WIDTH_REG-1:0] new_pix;
    logic [ADDR_W-1:0]       lb_addr;
    logic                    beat;
    logic                    in_line;
    logic                    emit;
    logic [15:0]             cen_col;
    logic [15:0]             cen_row;

    // Pad beats run unconditionally; real beats need a valid pixel.
    assign beat    = ready_o ? valid_i : 1'b1;
    assign new_pix = ready_o ? pixel_i : '0;
    assign in_line = (vcol < 16'(IMAGE_WIDTH));
    assign lb_addr = vcol[ADDR_W-1:0];
    assign emit    = beat && (vcol >= 16'(HW)) && (vrow >= 16'(HH));
    assign cen_col = vcol - 16'(HW);
    assign cen_row = vrow - 16'(HH);

    always_comb begin
        for (int k = 0; k < WINDOW_HEIGHT - 1; k++) begin
            col_in[k] = in_line ? line_buf[k][lb_addr] : '0;
        end
        col_in[WINDOW_HEIGHT-1] = new_pix;
        for (int i = 0; i < WINDOW_HEIGHT; i++) begin
            for (int j = 0; j < WINDOW_WIDTH - 1; j++) begin
                win_next[i][j] = win[i][j+1];
            end
            win_next[i][WINDOW_WIDTH-1] = col_in[i];
        end
    end

    // Out-of-image handling uses the centre coordinates only, so stale buffer data never leaks.
    always_comb begin
        int r;
        int c;
`ifdef SLIDING_WINDOW_REPLICATE_EN
        int rc;
        int cc;
        logic [$clog2(WINDOW_HEIGHT)-1:0] si;
        logic [$clog2(WINDOW_WIDTH)-1:0]  sj;
`endif
        for (int i = 0; i < WINDOW_HEIGHT; i++) begin
            for (int j = 0; j < WINDOW_WIDTH; j++) begin
                r = int'(cen_row) - HH + i;
                c = int'(cen_col) - HW + j;
`ifdef SLIDING_WINDOW_REPLICATE_EN
                rc = (r < 0) ? 0 : ((r >= IMAGE_HEIGHT) ? IMAGE_HEIGHT - 1 : r);
                cc = (c < 0) ? 0 : ((c >= IMAGE_WIDTH) ? IMAGE_WIDTH - 1 : c);
                si = $clog2(WINDOW_HEIGHT)'(rc - int'(cen_row) + HH);
                sj = $clog2(WINDOW_WIDTH)'(cc - int'(cen_col) + HW);
                win_out[i][j] = win_next[si][sj];
`else
                if (r >= 0 && r < IMAGE_HEIGHT && c >= 0 && c < IMAGE_WIDTH) begin
                    win_out[i][j] = win_next[i][j];
                end else begin
                    win_out[i][j] = '0;
                end
`endif
            end
        end
    end

    // Line buffers hold the previous rows; each beat rotates one column upward.
    always_ff @(posedge clk_i) begin
        if (beat && in_line) begin
            for (int k = 0; k < WINDOW_HEIGHT - 2; k++) begin
                line_buf[k][lb_addr] <= line_buf[k+1][lb_addr];
            end
            line_buf[WINDOW_HEIGHT-2][lb_addr] <= new_pix;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ACCEPT;
            ready_o <= 1'b1;
            vcol    <= '0;
            vrow    <= '0;
            valid_o <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
            for (int i = 0; i < WINDOW_HEIGHT; i++) begin
                for (int j = 0; j < WINDOW_WIDTH; j++) begin
                    win[i][j]      <= '0;
                    window_o[i][j] <= '0;
                end
            end
        end else begin
            valid_o <= emit;
            if (emit) begin
                window_o <= win_out;
                col_o    <= cen_col;
                row_o    <= cen_row;
            end
            if (beat) begin
                win <= win_next;
                if (vcol == LAST_VCOL) begin
                    vcol <= '0;
                    vrow <= (vrow == LAST_VROW) ? '0 : vrow + 16'd1;
                end else begin
                    vcol <= vcol + 16'd1;
                end
                case (state)
                    ACCEPT: begin
                        if (vcol == LAST_REAL_COL) begin
                            state   <= (vrow == LAST_REAL_ROW) ? FRAME_PAD : ROW_PAD;
                            ready_o <= 1'b0;
                        end
                    end
                    ROW_PAD: begin
                        if (vcol == LAST_VCOL) begin
                            state   <= ACCEPT;
                            ready_o <= 1'b1;
                        end
                    end
                    FRAME_PAD: begin
                        if (vcol == LAST_VCOL && vrow == LAST_VROW) begin
                            state   <= ACCEPT;
                            ready_o <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ACCEPT;
                        ready_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sliding_window_fp.md
Name: sliding_window_fp

Overview:
- Streaming 2-D window generator directly upstream of the per-kernel convolution wrappers (e.g. the 5x5 dy/dx derivative stages).
- Accepts one fp pixel per beat in raster order. Produces one WINDOW_HEIGHT x WINDOW_WIDTH window per image pixel, centred on that pixel, tagged with the centre col/row and a valid strobe.
- Uses internal line buffers plus a window shift register. Borders are zero-padded.

Parameters:
- EXP_WIDTH, 5, fp exponent width
- FRAC_WIDTH, 10, fp fraction width
- WINDOW_WIDTH, 5, window columns (odd, >=3)
- WINDOW_HEIGHT, 5, window rows (odd, >=3)
- IMAGE_WIDTH, 640, pixels per row (> WINDOW_WIDTH)
- IMAGE_HEIGHT, 480, rows per frame (> WINDOW_HEIGHT)
- FP_WIDTH_REG, 1+FRAC_WIDTH+EXP_WIDTH, pixel width (local)
- HW / HH, WINDOW_WIDTH/2 and WINDOW_HEIGHT/2, half-window sizes (local)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- pixel_i  in  FP_WIDTH_REG  raster-order input pixel
- valid_i  in  1  pixel_i valid; beat accepted when valid_i && ready_o
- ready_o  out  1  block can accept a real pixel this cycle
- window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  window; window_o[i][j] = pixel(row_o-HH+i, col_o-HW+j)
- col_o  out  16  centre column
- row_o  out  16  centre row
- valid_o  out  1  window_o/col_o/row_o valid, single-cycle strobe

Behaviour:
- Virtual grid: (IMAGE_WIDTH+HW) columns x (IMAGE_HEIGHT+HH) rows, traversed in raster order. Counters vcol and vrow cover this grid.
- Real pixels occupy vcol<IMAGE_WIDTH and vrow<IMAGE_HEIGHT. All other positions are pad beats that the block generates itself.
- FSM states:
  - ACCEPT: ready_o=1. Each accepted beat is one virtual beat. When the IMAGE_WIDTH-th pixel of a row is accepted, go to ROW_PAD. When that pixel is the last pixel of the frame, go to FRAME_PAD instead.
  - ROW_PAD: ready_o=0. Issue exactly HW pad beats, one per cycle, then return to ACCEPT.
  - FRAME_PAD: ready_o=0. Issue HW + HH*(IMAGE_WIDTH+HW) pad beats, one per cycle. Then clear vcol/vrow and return to ACCEPT.
- valid_i is ignored whenever ready_o=0. Idle cycles in ACCEPT (valid_i=0) advance nothing.
- Line buffers: WINDOW_HEIGHT-1 rows of IMAGE_WIDTH entries each. Written on every virtual beat with vcol<IMAGE_WIDTH; pad rows write zero.
- Window shift register: one column shift per virtual beat.
- Emission:
  - A virtual beat at (vcol,vrow) with vcol>=HW and vrow>=HH emits a window centred at (vcol-HW, vrow-HH).
  - Outputs are registered, so valid_o is asserted the cycle after that beat.
- Masking: any window element whose image coordinate lies outside [0,IMAGE_WIDTH) x [0,IMAGE_HEIGHT) is forced to +0 (all bits 0). The mask is computed from col/row, never from stale buffer contents.
- Frame totals: exactly IMAGE_WIDTH*IMAGE_HEIGHT valid_o pulses per frame, in raster order of the centre pixel.
- Minimum frame time: (IMAGE_WIDTH+HW)*(IMAGE_HEIGHT+HH) cycles.
- Reset values: valid_o=0, col_o=0, row_o=0, window_o all 0, ready_o=1, FSM=ACCEPT, vcol=vrow=0.
  - Line-buffer RAM is not cleared.
- Reset mid-frame: the next accepted pixel is treated as pixel (0,0). Masking and raster order guarantee no data from the aborted frame appears in any output window.
- No backpressure on the output side: the downstream stage always accepts.

Optional Feature:
- Macro: SLIDING_WINDOW_REPLICATE_EN.
- Defined: out-of-image elements take the value of the nearest in-image element, with row and column indices clamped independently. The clamped source is always inside the current window, so this is implemented as a per-element mux on the window register.
- Not defined: out-of-image elements are +0.
- Latency, handshake and FSM are identical in both cases.

Test Plan:
All tests use IMAGE_WIDTH=8, IMAGE_HEIGHT=6, 5x5 window, and pixel tag = fp16 value of row*8+col.
- Reset check: hold rst_i 3 cycles, then inspect → valid_o=0, ready_o=1, col_o=row_o=0, window_o all zero.
- Single frame, valid_i held high:
  - ready_o low for exactly 2 cycles after each 8th accepted pixel, and low for 2+2*10=22 cycles after pixel 47.
  - 48 valid_o pulses; col/row sequence (0,0)..(7,5).
- Window at (0,0):
  - Emitted 1 cycle after pixel (2,2) is accepted.
  - window_o[2][2]=fp16(0), [4][4]=fp16(18), [2][4]=fp16(2); rows 0-1 and columns 0-1 are zero.
- Window at (7,5): window_o[2][2]=fp16(47), [0][2]=fp16(31); columns 3-4 and rows 3-4 are zero.
- Random valid_i gaps (~50% duty): window_o/col_o/row_o sequence identical to the gap-free run; valid_i pulses presented while ready_o=0 are not consumed.
- rst_i asserted mid-row 3, then a full frame with a new tag offset (+100): every window matches the expected values for the new frame; no old tag values appear.
- With SLIDING_WINDOW_REPLICATE_EN: window (0,0) has [0][0]=fp16(0) and [0][4]=fp16(2).
